// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges pipeline writebacks with buffered long-latency results onto one regfile write port.
module writeback_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    input  logic        lr_valid_i,
    output logic        lr_ready_o,
    input  logic [4:0]  lr_addr_i,
    input  logic [31:0] lr_data_i,
    input  logic        issue_valid_i,
    input  logic [4:0]  issue_addr_i,
    input  logic [4:0]  query1_addr_i,
    output logic        query1_busy_async_o,
    input  logic [4:0]  query2_addr_i,
    output logic        query2_busy_async_o,
    output logic        stall_o,
    output logic        write_enable_o,
    output logic [4:0]  write_addr_o,
    output logic [31:0] write_data_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]  mem_addr [FIFO_DEPTH];
    logic [31:0] mem_data [FIFO_DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;
    logic [CW-1:0] starve_cnt;
    logic [31:0] busy, busy_n;
    logic        empty, full, push, pop, pipe_win, clr;
    logic [4:0]  head_addr;
    logic [31:0] head_data;

    assign empty      = wr_ptr == rd_ptr;
    assign full       = (wr_ptr ^ rd_ptr) == {1'b1, {PW{1'b0}}};
    assign lr_ready_o = !full;
    assign push       = lr_valid_i && !full;
    assign pipe_win   = wb_valid_i && wb_addr_i != 5'd0;
    assign pop        = !empty && !pipe_win;
    assign head_addr  = mem_addr[rd_ptr[PW-1:0]];
    assign head_data  = mem_data[rd_ptr[PW-1:0]];
    assign clr        = pop && head_addr != 5'd0;

    assign query1_busy_async_o = busy[query1_addr_i];
    assign query2_busy_async_o = busy[query2_addr_i];

    // set after clear so a same-cycle issue keeps the register busy
    always_comb begin
        busy_n = busy;
        if (clr) busy_n[head_addr] = 1'b0;
        if (issue_valid_i) busy_n[issue_addr_i] = 1'b1;
        busy_n[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_addr[wr_ptr[PW-1:0]] <= lr_addr_i;
            mem_data[wr_ptr[PW-1:0]] <= lr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            starve_cnt     <= '0;
            busy           <= '0;
            stall_o        <= 1'b0;
            write_enable_o <= 1'b0;
            write_addr_o   <= 5'd0;
            write_data_o   <= 32'd0;
        end else begin
            wr_ptr         <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr         <= pop ? rd_ptr + 1'b1 : rd_ptr;
            starve_cnt     <= (empty || pop) ? '0 :
                              (starve_cnt == CW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + CW'(1);
            busy           <= busy_n;
            stall_o        <= !pop && (stall_o || starve_cnt == CW'(STARVE_LIMIT));
            write_enable_o <= pipe_win || clr;
            write_addr_o   <= pipe_win ? wb_addr_i : pop ? head_addr : 5'd0;
            write_data_o   <= pipe_win ? wb_data_i : pop ? head_data : 32'd0;
            assert (!(wb_valid_i && stall_o));
            assert (!(pipe_win && busy[wb_addr_i]));
            assert (!(issue_valid_i && busy[issue_addr_i] && !(clr && head_addr == issue_addr_i)));
            assert (!(lr_valid_i && full));
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed checks of arbitration, FIFO, starvation stall and scoreboard.
module tb_writeback_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        wb_valid_i = 1'b0;
    logic [4:0]  wb_addr_i = 5'd0;
    logic [31:0] wb_data_i = 32'd0;
    logic        lr_valid_i = 1'b0;
    logic        lr_ready_o;
    logic [4:0]  lr_addr_i = 5'd0;
    logic [31:0] lr_data_i = 32'd0;
    logic        issue_valid_i = 1'b0;
    logic [4:0]  issue_addr_i = 5'd0;
    logic [4:0]  query1_addr_i = 5'd0;
    logic        query1_busy_async_o;
    logic [4:0]  query2_addr_i = 5'd0;
    logic        query2_busy_async_o;
    logic        stall_o;
    logic        write_enable_o;
    logic [4:0]  write_addr_o;
    logic [31:0] write_data_o;
    int compared = 0;
    int mismatched = 0;

    writeback_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .lr_valid_i(lr_valid_i), .lr_ready_o(lr_ready_o), .lr_addr_i(lr_addr_i), .lr_data_i(lr_data_i),
        .issue_valid_i(issue_valid_i), .issue_addr_i(issue_addr_i),
        .query1_addr_i(query1_addr_i), .query1_busy_async_o(query1_busy_async_o),
        .query2_addr_i(query2_addr_i), .query2_busy_async_o(query2_busy_async_o),
        .stall_o(stall_o), .write_enable_o(write_enable_o),
        .write_addr_o(write_addr_o), .write_data_o(write_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".we"}, {31'd0, write_enable_o}, {31'd0, we});
        chk({tag, ".addr"}, {27'd0, write_addr_o}, {27'd0, a});
        chk({tag, ".data"}, write_data_o, d);
    endtask

    initial begin
        step();
        chk_wr("reset", 1'b0, 5'd0, 32'd0);
        chk("reset.stall", {31'd0, stall_o}, 32'd0);
        chk("reset.ready", {31'd0, lr_ready_o}, 32'd1);
        step();
        rst_i = 1'b0;

        // test 1: issue x5, then its long-latency result returns
        issue_valid_i = 1'b1; issue_addr_i = 5'd5; query1_addr_i = 5'd5;
        step();
        issue_valid_i = 1'b0;
        chk("t1.busy_set", {31'd0, query1_busy_async_o}, 32'd1);
        lr_valid_i = 1'b1; lr_addr_i = 5'd5; lr_data_i = 32'hDEADBEEF;
        step();
        lr_valid_i = 1'b0;
        chk("t1.no_write_yet", {31'd0, write_enable_o}, 32'd0);
        chk("t1.still_busy", {31'd0, query1_busy_async_o}, 32'd1);
        step();
        chk_wr("t1.write", 1'b1, 5'd5, 32'hDEADBEEF);
        chk("t1.busy_clr", {31'd0, query1_busy_async_o}, 32'd0);

        // test 2: pipeline and long-latency collide, pipeline first
        issue_valid_i = 1'b1; issue_addr_i = 5'd7; query1_addr_i = 5'd7; query2_addr_i = 5'd7;
        step();
        issue_valid_i = 1'b0;
        wb_valid_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'h11;
        lr_valid_i = 1'b1; lr_addr_i = 5'd7; lr_data_i = 32'h22;
        step();
        wb_valid_i = 1'b0; lr_valid_i = 1'b0;
        chk_wr("t2.wb_write", 1'b1, 5'd3, 32'h11);
        chk("t2.x7_busy", {31'd0, query1_busy_async_o}, 32'd1);
        step();
        chk_wr("t2.lr_write", 1'b1, 5'd7, 32'h22);
        chk("t2.x7_free", {31'd0, query2_busy_async_o}, 32'd0);

        // test 3: fill FIFO under continuous pipeline traffic, starvation stall, drain
        wb_valid_i = 1'b1; wb_addr_i = 5'd1; wb_data_i = 32'h100;
        lr_valid_i = 1'b1; lr_addr_i = 5'd10; lr_data_i = 32'hA0;
        step();
        chk("t3.ready_one", {31'd0, lr_ready_o}, 32'd1);
        lr_addr_i = 5'd11; lr_data_i = 32'hB0; wb_data_i = 32'h101;
        step();
        lr_valid_i = 1'b0;
        chk("t3.ready_full", {31'd0, lr_ready_o}, 32'd0);
        chk_wr("t3.wb_wins", 1'b1, 5'd1, 32'h101);
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("t3.no_stall_c%0d", i), {31'd0, stall_o}, 32'd0);
            step();
        end
        chk("t3.stall", {31'd0, stall_o}, 32'd1);
        chk("t3.ready_still_full", {31'd0, lr_ready_o}, 32'd0);
        wb_valid_i = 1'b0;
        step();
        chk_wr("t3.drain0", 1'b1, 5'd10, 32'hA0);
        chk("t3.stall_drop", {31'd0, stall_o}, 32'd0);
        chk("t3.ready_back", {31'd0, lr_ready_o}, 32'd1);
        step();
        chk_wr("t3.drain1", 1'b1, 5'd11, 32'hB0);
        step();
        chk("t3.idle", {31'd0, write_enable_o}, 32'd0);

        // test 4: re-issue of x9 in the cycle its old result pops
        issue_valid_i = 1'b1; issue_addr_i = 5'd9; query1_addr_i = 5'd9;
        step();
        issue_valid_i = 1'b0;
        lr_valid_i = 1'b1; lr_addr_i = 5'd9; lr_data_i = 32'h99;
        step();
        lr_valid_i = 1'b0;
        issue_valid_i = 1'b1; issue_addr_i = 5'd9;
        step();
        issue_valid_i = 1'b0;
        chk_wr("t4.write", 1'b1, 5'd9, 32'h99);
        chk("t4.set_wins", {31'd0, query1_busy_async_o}, 32'd1);
        issue_valid_i = 1'b1; issue_addr_i = 5'd0; query2_addr_i = 5'd0;
        step();
        issue_valid_i = 1'b0;
        chk("t4.x0_never_busy", {31'd0, query2_busy_async_o}, 32'd0);

        // test 5: wb to x0 does not block the FIFO head
        lr_valid_i = 1'b1; lr_addr_i = 5'd4; lr_data_i = 32'h44;
        step();
        lr_valid_i = 1'b0;
        wb_valid_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'hFF;
        chk("t5.no_write", {31'd0, write_enable_o}, 32'd0);
        step();
        wb_valid_i = 1'b0;
        chk_wr("t5.fifo_write", 1'b1, 5'd4, 32'h44);
        step();
        chk("t5.idle", {31'd0, write_enable_o}, 32'd0);

        // test 6: reset in the middle of a stall with busy registers and full FIFO
        issue_valid_i = 1'b1; issue_addr_i = 5'd12; query1_addr_i = 5'd12;
        step();
        issue_valid_i = 1'b0;
        wb_valid_i = 1'b1; wb_addr_i = 5'd1; wb_data_i = 32'h200;
        lr_valid_i = 1'b1; lr_addr_i = 5'd13; lr_data_i = 32'hC0;
        step();
        lr_addr_i = 5'd14; lr_data_i = 32'hD0;
        step();
        lr_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("t6.stall", {31'd0, stall_o}, 32'd1);
        chk("t6.busy12", {31'd0, query1_busy_async_o}, 32'd1);
        wb_valid_i = 1'b0; rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk_wr("t6.after_rst", 1'b0, 5'd0, 32'd0);
        chk("t6.stall_clr", {31'd0, stall_o}, 32'd0);
        chk("t6.ready", {31'd0, lr_ready_o}, 32'd1);
        chk("t6.busy12_clr", {31'd0, query1_busy_async_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t6.no_stale%0d", i), {31'd0, write_enable_o}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
